// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready input, range checking and a scan mode.
// Latency: 1 cycle from an accepted sel (or a mode change) to y/y_idx/y_valid.
// Backpressure: in_ready drops while disabled, in scan mode or while leaving scan; outputs are never stalled.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                global enable; low freezes every register
//   mode              0 = decode, 1 = scan
//   in_valid/in_ready handshake qualifying sel
//   sel               binary index to decode
//   y, y_idx, y_valid registered one-hot output, its index, and its validity
//   scan_wrap         one-cycle pulse when the scan index returns to 0
//   err, err_clr      sticky out-of-range flag and its synchronous clear
module decoder_onehot_seq #(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   y_idx,
  output logic               y_valid,
  output logic               scan_wrap,
  output logic               err,
  input  logic               err_clr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);
  // One extra bit so NUM_OUT == 2**SEL_W is representable and never flags an error.
  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OUT-1:0] r_y;
  logic [SEL_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_wrap;
  logic               r_err;

  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_OUT-1:0] w_y_nxt;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic               w_valid_nxt;
  logic               w_wrap_nxt;
  logic               w_err_nxt;

  logic               w_hs;
  logic               w_sel_ok;
  logic [SEL_W-1:0]   w_idx_adv;

  function automatic logic [NUM_OUT-1:0] f_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign in_ready  = en & ~mode & (r_state != ST_SCAN);
  assign w_hs      = in_valid & in_ready;
  assign w_sel_ok  = ({1'b0, sel} < NUM_OUT_X);
  // Scan wraps at NUM_OUT-1 rather than at the natural binary rollover.
  assign w_idx_adv = (r_idx == LAST_IDX) ? '0 : r_idx + SEL_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_err;

    if (en) begin
      if (err_clr) w_err_nxt = 1'b0;

      if (r_state == ST_SCAN) begin
        if (!mode) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_y_nxt     = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt  = '0;
          w_idx_nxt  = w_idx_adv;
          w_y_nxt    = f_onehot(w_idx_adv);
          w_wrap_nxt = (r_idx == LAST_IDX);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else if (mode) begin
        w_state_nxt = ST_SCAN;
        w_cnt_nxt   = '0;
        w_y_nxt     = f_onehot('0);
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b1;
      end else if (w_hs) begin
        w_state_nxt = ST_DECODE;
        if (w_sel_ok) begin
          w_y_nxt     = f_onehot(sel);
          w_idx_nxt   = sel;
          w_valid_nxt = 1'b1;
        end else begin
          // Bad index: blank the outputs but keep the last good y_idx.
          w_y_nxt     = '0;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;  // overrides a simultaneous err_clr
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign y         = r_y;
  assign y_idx     = r_idx;
  assign y_valid   = r_valid;
  assign scan_wrap = r_wrap;
  assign err       = r_err;

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
Parametrised, registered binary-to-one-hot decoder and the successor to the fixed 2-to-4 combinational decoders. It adds a non-power-of-two output count, a valid/ready input handshake, range checking with a sticky error flag, and an autonomous scan mode that walks a single one across the outputs. It drives one-hot selects such as bank, row or digit enables.

Parameters:
SEL_W, 3, width of the binary select input (>=1)
NUM_OUT, 8, number of one-hot outputs; 2 <= NUM_OUT <= 2**SEL_W
SCAN_DIV, 4, clock cycles per scan step (>=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  global enable; 0 freezes all state
mode  input  1  0 = DECODE, 1 = SCAN
in_valid  input  1  sel is valid this cycle
in_ready  output  1  block accepts sel; combinational: en & ~mode & (state != SCAN)
sel  input  SEL_W  binary index to decode
y  output  NUM_OUT  registered one-hot output (or all zero)
y_idx  output  SEL_W  registered binary index of the active y bit
y_valid  output  1  y holds a valid one-hot value
scan_wrap  output  1  one-cycle pulse when the scan index wraps to 0
err  output  1  sticky flag, set by an out-of-range sel
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, y_idx=0, y_valid=0, scan_wrap=0, err=0.
  - State = IDLE; divider counter = 0.
- States are IDLE, DECODE and SCAN. All registered outputs change only on clk edges.
- en=0: state, counter and all outputs hold their values; scan_wrap=0; err_clr is ignored.
- IDLE/DECODE with mode=0: a handshake occurs when in_valid & in_ready. Latency is 1 cycle.
  - If sel < NUM_OUT: y = 1<<sel, y_idx = sel, y_valid = 1; state becomes DECODE.
  - If sel >= NUM_OUT: y = 0, y_idx unchanged, y_valid = 0, err = 1; state becomes DECODE.
- Without a handshake, y, y_idx and y_valid hold. There is no back-pressure on outputs; each new handshake overwrites them.
- mode=1 in IDLE/DECODE: next cycle y = 1 (bit 0), y_idx = 0, y_valid = 1, counter = 0, state becomes SCAN.
- SCAN:
  - The counter increments every cycle. When it reaches SCAN_DIV-1 it resets to 0 and the index advances by 1.
  - At index NUM_OUT-1 the index wraps to 0, not to 2**SEL_W-1; scan_wrap = 1 for that single cycle.
  - y is always 1<<y_idx and y_valid = 1.
- SCAN with mode=0: next cycle y = 0, y_valid = 0, y_idx = 0, counter = 0, state becomes IDLE.
- mode is sampled every cycle. in_valid is ignored while mode=1.
- err_clr=1 clears err next cycle. If a new range error occurs in the same cycle as err_clr, the set wins and err = 1.
- y is one-hot or zero at all times; a bench assertion checks $onehot0(y).
- Reset mid-scan or mid-handshake returns to the reset values immediately.
- SCAN_DIV=1: the index advances every cycle.

Test Plan:
- Reset then decode: SEL_W=3, NUM_OUT=8; in_valid=1 with sel=5 -> 1 cycle later y=8'b0010_0000, y_idx=5, y_valid=1.
- Range error with clear: NUM_OUT=6, sel=7 -> y=0, y_valid=0, err=1. Assert err_clr together with another out-of-range sel -> err stays 1. Assert err_clr alone -> err=0.
- Scan wrap: NUM_OUT=6, SCAN_DIV=4, mode=1 for 30 cycles -> y steps 1,2,4,8,16,32,1 every 4 cycles; scan_wrap pulses once, on the 32->1 transition (24 cycles after entering scan).
- Scan exit and handshake block: mode=1 with in_valid=1 -> in_ready=0 and sel is ignored. mode->0 -> next cycle y=0, y_valid=0, IDLE, in_ready=1.
- Freeze: in scan at y_idx=3, hold en=0 for 10 cycles -> y, y_idx and counter are unchanged. en=1 -> scan resumes from the held counter value.
- Async reset: assert rst_n=0 between clock edges during a scan -> y=0, y_valid=0 immediately, without waiting for clk.
